// File: rtl/rx_frame_seq.sv
// Receive-frame sequencer: splits a Wishbone-style sample stream into OFDM
// symbols, tags each forwarded beat and caps the number of symbols per frame.
//
// state | meaning
// IDLE  | no frame open, counters at 0, waiting for the first beat
// RUN   | forwarding beats, tagging symbol index / start / preamble
// DROP  | symbol limit reached, beats acked and discarded
// CLOSE | upstream frame ended, draining the output register
module rx_frame_seq #(
   parameter int NFFT    = 2048,
   parameter int NPRE    = 2,
   parameter int MAX_SYM = 64,
   parameter int SW      = 8
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [31:0]   DAT_I,
   input  logic          CYC_I,
   input  logic          STB_I,
   input  logic          WE_I,
   output logic          ACK_O,
   output logic [31:0]   DAT_O,
   output logic          CYC_O,
   output logic          STB_O,
   output logic          WE_O,
   input  logic          ACK_I,
   output logic          SOS_O,
   output logic          PRE_O,
   output logic [SW-1:0] SYM_IDX_O,
   output logic          FRAME_DONE_O,
   output logic          ERR_PART_O,
   output logic          ERR_OVF_O
);

   localparam int LW = $clog2(NFFT);
   localparam logic [LW-1:0] SAMP_LAST = LW'(NFFT - 1);
   localparam logic [SW:0]   SYM_LAST  = (SW+1)'(MAX_SYM - 1);
   localparam logic [SW:0]   NPRE_C    = (SW+1)'(NPRE);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DROP,
      ST_CLOSE
   } state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   samp_q, samp_d;
   logic [SW:0]     sym_q, sym_d;
   logic [31:0]     dat_q, dat_d;
   logic            we_q, we_d;
   logic            sos_q, sos_d;
   logic            pre_q, pre_d;
   logic [SW-1:0]   idx_q, idx_d;
   logic            stb_q, stb_d;
   logic            cyc_q, cyc_d;
   logic            done_q, done_d;
   logic            err_part_q, err_part_d;
   logic            err_ovf_q, err_ovf_d;
   logic            ack;
   logic            in_xfer;
   logic            out_xfer;
   logic            load;

   // Upstream accept: back-pressure passes straight through while forwarding.
   always_comb begin
      ack = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN: ack = ~stb_q | ACK_I;
         ST_DROP:         ack = 1'b1;
         default:         ack = 1'b0;
      endcase
   end

   assign in_xfer  = STB_I & CYC_I & ack;
   assign out_xfer = stb_q & ACK_I;

   // Next-state, counter and output-register logic.
   always_comb begin
      state_d    = state_q;
      samp_d     = samp_q;
      sym_d      = sym_q;
      dat_d      = dat_q;
      we_d       = we_q;
      sos_d      = sos_q;
      pre_d      = pre_q;
      idx_d      = idx_q;
      stb_d      = stb_q & ~out_xfer;
      cyc_d      = cyc_q;
      done_d     = 1'b0;
      err_part_d = err_part_q;
      err_ovf_d  = err_ovf_q;
      load       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_xfer) begin
               load       = 1'b1;
               cyc_d      = 1'b1;
               err_part_d = 1'b0;
               err_ovf_d  = 1'b0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!CYC_I) begin
               err_part_d = (samp_q != '0);
               state_d    = ST_CLOSE;
            end else if (in_xfer) begin
               load = 1'b1;
               if (samp_q == SAMP_LAST && sym_q == SYM_LAST) begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (!CYC_I) begin
               state_d = ST_CLOSE;
            end else if (in_xfer) begin
               err_ovf_d = 1'b1;
            end
         end
         default: begin
            if (!stb_q || out_xfer) begin
               cyc_d   = 1'b0;
               done_d  = 1'b1;
               stb_d   = 1'b0;
               samp_d  = '0;
               sym_d   = '0;
               state_d = ST_IDLE;
            end
         end
      endcase

      // A new beat overwrites the output register even if it drains this cycle.
      if (load) begin
         dat_d = DAT_I;
         we_d  = WE_I;
         sos_d = (samp_q == '0);
         pre_d = (sym_q < NPRE_C);
         idx_d = sym_q[SW-1:0];
         stb_d = 1'b1;
         if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            sym_d  = sym_q + 1'b1;
         end else begin
            samp_d = samp_q + 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q    <= ST_IDLE;
         samp_q     <= '0;
         sym_q      <= '0;
         dat_q      <= '0;
         we_q       <= 1'b0;
         sos_q      <= 1'b0;
         pre_q      <= 1'b0;
         idx_q      <= '0;
         stb_q      <= 1'b0;
         cyc_q      <= 1'b0;
         done_q     <= 1'b0;
         err_part_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         samp_q     <= samp_d;
         sym_q      <= sym_d;
         dat_q      <= dat_d;
         we_q       <= we_d;
         sos_q      <= sos_d;
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         stb_q      <= stb_d;
         cyc_q      <= cyc_d;
         done_q     <= done_d;
         err_part_q <= err_part_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   assign ACK_O        = ack;
   assign DAT_O        = dat_q;
   assign CYC_O        = cyc_q;
   assign STB_O        = stb_q;
   assign WE_O         = we_q;
   assign SOS_O        = sos_q;
   assign PRE_O        = pre_q;
   assign SYM_IDX_O    = idx_q;
   assign FRAME_DONE_O = done_q;
   assign ERR_PART_O   = err_part_q;
   assign ERR_OVF_O    = err_ovf_q;

endmodule
